call_return_ctrl: RTL
=====================

Name: call_return_ctrl

Overview:
Stack-client sequencer that drives the 8-bit STACK block's POP/PUSH/VALUE interface and consumes its OUTPUT on behalf of the CPU's CALL/RET instructions. On CALL it pushes the return address, then commands a program-counter jump. On RET it pops the return address, then commands a PC load with it. It tracks stack occupancy and flags overflow and underflow so the core can trap.

Parameters:
DEPTH, 255, maximum entries the controller allows on the stack (1..255); full when count == DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
CALL  input  1  call request, sampled only in IDLE
RET  input  1  return request, sampled only in IDLE
TARGET  input  8  call destination, latched on CALL accept
RET_ADDR  input  8  return address (PC+1), latched on CALL accept
CLR_ERR  input  1  synchronous clear of sticky error flags
STACK_OUT  input  8  STACK OUTPUT (valid combinationally while POP=1)
PUSH  output  1  STACK PUSH
POP  output  1  STACK POP
VALUE  output  8  STACK VALUE
PC_LOAD  output  1  one-cycle strobe: PC <= PC_VALUE
PC_VALUE  output  8  jump/return destination
BUSY  output  1  high whenever state != IDLE
OVERFLOW  output  1  sticky: CALL rejected, stack full
UNDERFLOW  output  1  sticky: RET rejected, stack empty
COUNT  output  8  current stack occupancy

Behaviour:
- Reset (rst=0, async): state=IDLE; PUSH=POP=PC_LOAD=BUSY=0; VALUE=PC_VALUE=0x00; COUNT=0; OVERFLOW=UNDERFLOW=0; internal latches cleared. Reset mid-sequence aborts it, with no PC_LOAD issued. The STACK shares the reset, so the pointers stay consistent.
- All outputs are registered or decoded from the registered state only. There are no combinational paths from CALL/RET to the outputs.
- States: IDLE, PUSH_RA, JUMP, POP_RA, RETURN.
- IDLE, CALL=1:
  - If COUNT < DEPTH: latch TARGET and RET_ADDR, then go to PUSH_RA.
  - Else: set OVERFLOW and stay in IDLE, with no stack or PC activity.
- IDLE, RET=1 and CALL=0:
  - If COUNT > 0: go to POP_RA.
  - Else: set UNDERFLOW and stay in IDLE.
- CALL and RET both high in IDLE: CALL has priority and RET is dropped.
- CALL/RET while BUSY: ignored, not queued. The requester must re-present the request after BUSY falls.
- PUSH_RA: PUSH=1, VALUE=latched RET_ADDR, exactly one cycle. COUNT increments at the exiting edge. Next state is JUMP.
- JUMP: PC_LOAD=1, PC_VALUE=latched TARGET, one cycle. Next state is IDLE.
- POP_RA: POP=1, VALUE=0x00, one cycle. STACK_OUT is captured into the return register at the exiting edge. COUNT decrements. Next state is RETURN.
- RETURN: PC_LOAD=1, PC_VALUE=captured return address, one cycle. Next state is IDLE.
- Latency: a CALL accepted at edge N gives PUSH during cycle N+1 and PC_LOAD during cycle N+2. RET has the same timing. BUSY is high in cycles N+1 and N+2. Back-to-back requests can therefore be accepted every 3 cycles.
- PUSH and POP are never high together. PC_LOAD is never high in the same cycle as PUSH or POP.
- PC_VALUE holds its last value outside PC_LOAD cycles. VALUE is 0x00 outside PUSH_RA.
- COUNT never wraps. It saturates logically because the full/empty checks prevent wrap.
- OVERFLOW/UNDERFLOW are sticky until CLR_ERR=1 at a clock edge. If CLR_ERR and a new error occur in the same cycle, the set wins.
- Arithmetic is 8-bit unsigned. RET_ADDR/TARGET are passed unmodified; the controller adds nothing.

Test Plan:
- Reset, then CALL with TARGET=0x40, RET_ADDR=0x11 -> cycle+1: PUSH=1, VALUE=0x11; cycle+2: PC_LOAD=1, PC_VALUE=0x40; COUNT=1; BUSY high for exactly 2 cycles.
- Nested CALLs pushing RA=0x11 then 0x22, followed by two RETs against a real STACK instance -> PC_LOAD values 0x22 then 0x11; COUNT returns to 0; POP high exactly 1 cycle per RET.
- RET with COUNT=0 -> UNDERFLOW=1; no POP and no PC_LOAD. CLR_ERR pulse -> UNDERFLOW=0.
- DEPTH=2: three CALLs -> third sets OVERFLOW; COUNT stays 2; no third PUSH. Simultaneous CALL and RET in IDLE with COUNT=1 -> CALL sequence only, COUNT=2.
- CALL accepted, then RET asserted during BUSY -> RET ignored; no POP in the following 3 cycles unless RET is re-presented.
- rst asserted low during POP_RA -> all outputs 0 immediately (async); no PC_LOAD after release; COUNT=0.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Sequencer between the CPU's CALL/RET instructions and an 8-bit hardware stack:
// pushes/pops the return address, then strobes a PC load with the destination.
module call_return_ctrl #(
  parameter int DEPTH = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       CALL,
  input  logic       RET,
  input  logic [7:0] TARGET,
  input  logic [7:0] RET_ADDR,
  input  logic       CLR_ERR,
  input  logic [7:0] STACK_OUT,
  output logic       PUSH,
  output logic       POP,
  output logic [7:0] VALUE,
  output logic       PC_LOAD,
  output logic [7:0] PC_VALUE,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic       UNDERFLOW,
  output logic [7:0] COUNT
);

  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  typedef enum logic [2:0] {IDLE, PUSH_RA, JUMP, POP_RA, RETURN} state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] ra_q, ra_d;
  logic [7:0] pc_q, pc_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic       ovf_set, unf_set;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tgt_d   = tgt_q;
    ra_d    = ra_q;
    pc_d    = pc_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (state_q)
      IDLE: begin
        // CALL wins over a simultaneous RET; the RET is simply dropped.
        if (CALL) begin
          if (count_q < DEPTH_C) begin
            tgt_d   = TARGET;
            ra_d    = RET_ADDR;
            state_d = PUSH_RA;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (RET) begin
          if (count_q != 8'd0) state_d = POP_RA;
          else                 unf_set = 1'b1;
        end
      end
      PUSH_RA: begin
        count_d = count_q + 8'd1;
        pc_d    = tgt_q;
        state_d = JUMP;
      end
      JUMP:    state_d = IDLE;
      POP_RA: begin
        // STACK_OUT is only valid while POP is high, so capture it here.
        count_d = count_q - 8'd1;
        pc_d    = STACK_OUT;
        state_d = RETURN;
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ovf_d = ovf_set | (ovf_q & ~CLR_ERR);
    unf_d = unf_set | (unf_q & ~CLR_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= 8'd0;
      tgt_q   <= 8'd0;
      ra_q    <= 8'd0;
      pc_q    <= 8'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tgt_q   <= tgt_d;
      ra_q    <= ra_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign PUSH      = (state_q == PUSH_RA);
  assign POP       = (state_q == POP_RA);
  assign VALUE     = PUSH ? ra_q : 8'h00;
  assign PC_LOAD   = (state_q == JUMP) || (state_q == RETURN);
  assign PC_VALUE  = pc_q;
  assign BUSY      = (state_q != IDLE);
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
  assign COUNT     = count_q;

endmodule
